// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode field location and fetch FSM states.
package cpu_pkg;

    localparam int ADDR_W = 16;
    localparam int INSTR_W = 16;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam logic [3:0] HALT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating 32-bit event counter with synchronous reset and clear.
module fetch_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        inc,
    output logic [31:0] count
);

    // Stops at all-ones so a long run never wraps back to a misleading small value.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 32'd0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, registers imem data and hands it to decode via valid/ready.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module instr_fetch_unit #(
    parameter int               ADDR_W      = cpu_pkg::ADDR_W,
    parameter int               INSTR_W     = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [3:0]       HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count,
`endif
    output logic               halted
);

    import cpu_pkg::*;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              fire;
    logic              is_halt;

    assign imem_addr = pc;
    assign fire      = (state == FETCH_RUN) && (!if_valid || if_ready);
    assign is_halt   = (imem_instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);

    // Redirect outranks fetch so a taken branch never lets a wrong-path word through.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH_IDLE;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
            halted   <= 1'b0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if_valid <= 1'b0;
                    if (redirect_valid) begin
                        pc <= redirect_target;
                    end
                    if (start) begin
                        state <= FETCH_RUN;
                    end
                end
                FETCH_RUN: begin
                    if (redirect_valid) begin
                        pc       <= redirect_target;
                        if_valid <= 1'b0;
                    end else if (fire) begin
                        if_instr <= imem_instr;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        pc       <= pc + ADDR_W'(1);
                        if (is_halt) begin
                            state  <= FETCH_HALT;
                            halted <= 1'b1;
                        end
                    end
                end
                FETCH_HALT: begin
                    if (redirect_valid) begin
                        pc       <= redirect_target;
                        if_valid <= 1'b0;
                        state    <= FETCH_RUN;
                        halted   <= 1'b0;
                    end else if (if_ready) begin
                        if_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= FETCH_IDLE;
                    if_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetch_inc;
    logic stall_inc;

    assign fetch_inc = fire && !redirect_valid;
    assign stall_inc = (state == FETCH_RUN) && if_valid && !if_ready && !redirect_valid;

    fetch_perf_counter u_fetch_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (fetch_inc),
        .count (fetch_count)
    );

    fetch_perf_counter u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (stall_inc),
        .count (stall_count)
    );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (default reset PC and a wrap-around reset PC).
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        halted;

    logic        rst1;
    logic        start1;
    logic [15:0] imem_addr1;
    logic [15:0] imem_instr1;
    logic        if_valid1;
    logic [15:0] if_instr1;
    logic [15:0] if_pc1;
    logic        halted1;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
    logic [31:0] fetch_count1;
    logic [31:0] stall_count1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory image: 0x1000+addr everywhere except a HALT word at address 5.
    assign imem_instr  = (imem_addr == 16'd5) ? 16'hF000 : 16'h1000 + imem_addr;
    assign imem_instr1 = (imem_addr1 == 16'd5) ? 16'hF000 : 16'h1000 + imem_addr1;

    instr_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count     (fetch_count),
        .stall_count     (stall_count),
`endif
        .halted          (halted)
    );

    instr_fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk             (clk),
        .rst             (rst1),
        .start           (start1),
        .redirect_valid  (1'b0),
        .redirect_target (16'h0000),
        .imem_addr       (imem_addr1),
        .imem_instr      (imem_instr1),
        .if_valid        (if_valid1),
        .if_ready        (1'b1),
        .if_instr        (if_instr1),
        .if_pc           (if_pc1),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count     (fetch_count1),
        .stall_count     (stall_count1),
`endif
        .halted          (halted1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic rv, input logic [15:0] tgt, input logic rdy);
        start           = s;
        redirect_valid  = rv;
        redirect_target = tgt;
        if_ready        = rdy;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkFetch(input string tag, input logic [15:0] pc, input logic [15:0] instr);
        checkOutput({tag, " valid"}, {31'd0, if_valid}, 32'd1);
        checkOutput({tag, " pc"}, {16'd0, if_pc}, {16'd0, pc});
        checkOutput({tag, " instr"}, {16'd0, if_instr}, {16'd0, instr});
    endtask

    initial begin
        rst = 1'b1;
        rst1 = 1'b1;
        start1 = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 16'h0000;
        if_ready = 1'b1;
        tick();
        tick();

        // Reset state
        checkOutput("rst valid", {31'd0, if_valid}, 32'd0);
        checkOutput("rst instr", {16'd0, if_instr}, 32'd0);
        checkOutput("rst if_pc", {16'd0, if_pc}, 32'd0);
        checkOutput("rst halted", {31'd0, halted}, 32'd0);
        checkOutput("rst addr", {16'd0, imem_addr}, 32'h0000);
        checkOutput("rst addr wrap", {16'd0, imem_addr1}, 32'hFFFE);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("idle valid", {31'd0, if_valid}, 32'd0);

        // Start and sequential fetch
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b1);
        checkOutput("start no valid", {31'd0, if_valid}, 32'd0);
        checkOutput("start addr", {16'd0, imem_addr}, 32'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkFetch("seq0", 16'h0000, 16'h1000);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkFetch("seq1", 16'h0001, 16'h1001);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkFetch("seq2", 16'h0002, 16'h1002);

        // Back-pressure stall for three cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
            checkFetch("stall", 16'h0002, 16'h1002);
            checkOutput("stall addr", {16'd0, imem_addr}, 32'h0003);
        end
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkFetch("resume", 16'h0003, 16'h1003);

        // Redirect while stalled drops the held word
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
        checkFetch("stall2", 16'h0003, 16'h1003);
        applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0);
        checkOutput("redir bubble", {31'd0, if_valid}, 32'd0);
        checkOutput("redir addr", {16'd0, imem_addr}, 32'h0040);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkFetch("redir target", 16'h0040, 16'h1040);

        // Run into the HALT word at address 5
        applyStimulus(1'b0, 1'b1, 16'h0003, 1'b1);
        checkOutput("redir3 bubble", {31'd0, if_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkFetch("pre3", 16'h0003, 16'h1003);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkFetch("pre4", 16'h0004, 16'h1004);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkFetch("halt word", 16'h0005, 16'hF000);
        checkOutput("halt flag", {31'd0, halted}, 32'd1);
        checkOutput("halt addr", {16'd0, imem_addr}, 32'h0006);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("halt drained", {31'd0, if_valid}, 32'd0);
        checkOutput("halt addr hold", {16'd0, imem_addr}, 32'h0006);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b1);
        checkOutput("halt ignores start", {31'd0, halted}, 32'd1);
        checkOutput("halt start addr", {16'd0, imem_addr}, 32'h0006);
        checkOutput("halt start valid", {31'd0, if_valid}, 32'd0);

        // Redirect out of HALT restarts at 0
        applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1);
        checkOutput("unhalt flag", {31'd0, halted}, 32'd0);
        checkOutput("unhalt valid", {31'd0, if_valid}, 32'd0);
        checkOutput("unhalt addr", {16'd0, imem_addr}, 32'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkFetch("restart", 16'h0000, 16'h1000);

        // Wrap-around reset PC on the second instance
        rst1 = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checkOutput("wrap start valid", {31'd0, if_valid1}, 32'd0);
        tick();
        checkOutput("wrap pc0", {16'd0, if_pc1}, 32'hFFFE);
        checkOutput("wrap instr0", {16'd0, if_instr1}, 32'h0FFE);
        tick();
        checkOutput("wrap pc1", {16'd0, if_pc1}, 32'hFFFF);
        tick();
        checkOutput("wrap pc2", {16'd0, if_pc1}, 32'h0000);
        checkOutput("wrap instr2", {16'd0, if_instr1}, 32'h1000);
        tick();
        checkOutput("wrap pc3", {16'd0, if_pc1}, 32'h0001);
        checkOutput("wrap valid3", {31'd0, if_valid1}, 32'd1);
        rst1 = 1'b1;
        tick();
        checkOutput("midrst valid", {31'd0, if_valid1}, 32'd0);
        checkOutput("midrst addr", {16'd0, imem_addr1}, 32'hFFFE);
        rst1 = 1'b0;
        tick();
        checkOutput("midrst idle", {31'd0, if_valid1}, 32'd0);
        checkOutput("midrst idle addr", {16'd0, imem_addr1}, 32'hFFFE);

        // IDLE redirect, then start together with redirect
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 16'h0010, 1'b1);
        checkOutput("idle redir addr", {16'd0, imem_addr}, 32'h0010);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("idle stays", {31'd0, if_valid}, 32'd0);
        checkOutput("idle addr hold", {16'd0, imem_addr}, 32'h0010);
        applyStimulus(1'b1, 1'b1, 16'h0100, 1'b1);
        checkOutput("start+redir valid", {31'd0, if_valid}, 32'd0);
        checkOutput("start+redir addr", {16'd0, imem_addr}, 32'h0100);

        // Ten fetches, then four stall cycles
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
        end
        checkFetch("burst last", 16'h0109, 16'h1109);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
        end
        checkFetch("burst stall", 16'h0109, 16'h1109);
        checkOutput("burst stall addr", {16'd0, imem_addr}, 32'h010A);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("fetch_count", fetch_count, 32'd10);
        checkOutput("stall_count", stall_count, 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
